// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch count datapath.
// Digit layout in the packed vector is {M1,M0,S1,S0,H1,H0}.
package stopwatch_pkg;
  localparam int BCD_W    = 4;
  localparam int DIGITS_W = 6 * BCD_W;

  localparam int H_MAX  = 9;
  localparam int H1_MAX = 9;
  localparam int S0_MAX = 9;
  localparam int S1_MAX = 5;
  localparam int M0_MAX = 9;
  localparam int M1_MAX = 5;

  localparam int H0_OFF = 0;
  localparam int H1_OFF = 4;
  localparam int S0_OFF = 8;
  localparam int S1_OFF = 12;
  localparam int M0_OFF = 16;
  localparam int M1_OFF = 20;

  localparam logic [DIGITS_W-1:0] MAX_TIME  = 24'h595999;
  localparam logic [DIGITS_W-1:0] ZERO_TIME = 24'h000000;

  typedef logic [BCD_W-1:0] bcd_t;
endpackage

// File: rtl/stopwatch_count_datapath_bcd_digit.sv
// One BCD digit of the ripple chain: inc/dec with carry/borrow.
// Carry/borrow depend only on the request and value, never on hold.
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter int MAX = 9
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic hold_i,
  input  logic inc_i,
  input  logic dec_i,
  output bcd_t q_o,
  output logic carry_o,
  output logic borrow_o
);
  localparam bcd_t MAX_V = bcd_t'(MAX);

  bcd_t q_q, q_d;

  assign carry_o  = inc_i && (q_q == MAX_V);
  assign borrow_o = dec_i && (q_q == '0);
  assign q_o      = q_q;

  // next value: clear, then step unless the chain is held
  always_comb begin
    q_d = q_q;
    if (clr_i)
      q_d = '0;
    else if (!hold_i && inc_i)
      q_d = carry_o ? '0 : q_q + 1'b1;
    else if (!hold_i && dec_i)
      q_d = borrow_o ? MAX_V : q_q - 1'b1;
  end

  // digit register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) q_q <= '0;
    else       q_q <= q_d;
  end
endmodule

// File: rtl/stopwatch_count_datapath.sv
// MM:SS.hh BCD stopwatch count with prescaler, jog, lap and blink.
// Build option STOPWATCH_WRAP_EN: count-up wraps at 59:59.99.
module stopwatch_count_datapath
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV  = 500000,
  parameter int BLINK_DIV = 12500000,
  parameter int DIV_W     = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                up,
  input  logic                resetCount,
  input  logic                flashState,
  input  logic                lapState,
  input  logic                manualTrigger,
  output logic                flashing,
  output logic [DIGITS_W-1:0] digits,
  output logic                blank,
  output logic                tick
);
  logic [DIV_W-1:0] presc_q, presc_d;
  logic [DIV_W-1:0] blink_q, blink_d;
  logic             tick_q, flashing_q;
  logic             blank_q, blank_d;
  logic             trig_q, lap_st_q;
  logic [DIGITS_W-1:0] lap_q, count;

  logic wrap_pt, tick_adv, step_try, jog;
  logic step_up, step_dn, jog_up, jog_dn;
  logic term_hit;
  logic c0, c1, c2, c3, c4, c5;
  logic b0, b1, b2, b3, b4, b5;
  bcd_t d0, d1, d2, d3, d4, d5;

  assign jog      = manualTrigger & ~trig_q;
  assign wrap_pt  = enable &&
                    (presc_q == DIV_W'(TICK_DIV - 1));
  assign tick_adv = wrap_pt & ~manualTrigger & ~resetCount;
  assign step_try = tick_adv & ~flashing_q;
  assign step_up  = step_try & up;
  assign step_dn  = step_try & ~up;
  assign jog_up   = jog & up;
  assign jog_dn   = jog & ~up;

`ifdef STOPWATCH_WRAP_EN
  assign term_hit = step_try & b5;
`else
  assign term_hit = step_try & (c5 | b5);
`endif

  bcd_digit #(.MAX(H_MAX)) u_h0 (
    .clk(clk), .reset(reset), .clr_i(resetCount),
    .hold_i(term_hit), .inc_i(step_up), .dec_i(step_dn),
    .q_o(d0), .carry_o(c0), .borrow_o(b0));
  bcd_digit #(.MAX(H1_MAX)) u_h1 (
    .clk(clk), .reset(reset), .clr_i(resetCount),
    .hold_i(term_hit), .inc_i(c0), .dec_i(b0),
    .q_o(d1), .carry_o(c1), .borrow_o(b1));
  bcd_digit #(.MAX(S0_MAX)) u_s0 (
    .clk(clk), .reset(reset), .clr_i(resetCount),
    .hold_i(term_hit), .inc_i(c1 | jog_up),
    .dec_i(b1 | jog_dn),
    .q_o(d2), .carry_o(c2), .borrow_o(b2));
  bcd_digit #(.MAX(S1_MAX)) u_s1 (
    .clk(clk), .reset(reset), .clr_i(resetCount),
    .hold_i(term_hit), .inc_i(c2), .dec_i(b2),
    .q_o(d3), .carry_o(c3), .borrow_o(b3));
  bcd_digit #(.MAX(M0_MAX)) u_m0 (
    .clk(clk), .reset(reset), .clr_i(resetCount),
    .hold_i(term_hit), .inc_i(c3), .dec_i(b3),
    .q_o(d4), .carry_o(c4), .borrow_o(b4));
  bcd_digit #(.MAX(M1_MAX)) u_m1 (
    .clk(clk), .reset(reset), .clr_i(resetCount),
    .hold_i(term_hit), .inc_i(c4), .dec_i(b4),
    .q_o(d5), .carry_o(c5), .borrow_o(b5));

  assign count = {d5, d4, d3, d2, d1, d0};

  // prescaler and blink next-state
  always_comb begin
    presc_d = presc_q;
    if (resetCount)
      presc_d = '0;
    else if (enable)
      presc_d = wrap_pt ? '0 : presc_q + 1'b1;
    blink_d = '0;
    blank_d = 1'b0;
    if (flashState) begin
      blink_d = blink_q + 1'b1;
      blank_d = blank_q;
      if (blink_q == DIV_W'(BLINK_DIV - 1)) begin
        blink_d = '0;
        blank_d = ~blank_q;
      end
    end
  end

  // count control: prescaler, tick pulse, terminal flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q    <= '0;
      tick_q     <= 1'b0;
      flashing_q <= 1'b0;
      trig_q     <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_adv;
      trig_q  <= manualTrigger;
      if (resetCount)    flashing_q <= 1'b0;
      else if (term_hit) flashing_q <= 1'b1;
    end
  end

  // display side: lap capture and blink phase
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lap_q    <= '0;
      lap_st_q <= 1'b0;
      blink_q  <= '0;
      blank_q  <= 1'b0;
    end else begin
      lap_st_q <= lapState;
      if (lapState && !lap_st_q) lap_q <= count;
      blink_q <= blink_d;
      blank_q <= blank_d;
    end
  end

  assign digits   = lapState ? lap_q : count;
  assign flashing = flashing_q;
  assign blank    = blank_q;
  assign tick     = tick_q;
endmodule

// File: tb/tb_stopwatch_count_datapath.sv
// Self-checking bench for stopwatch_count_datapath.
// Small dividers keep the run short.
module tb_stopwatch_count_datapath;
  import stopwatch_pkg::*;

  localparam int TD = 4;
  localparam int BD = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable, up, resetCount;
  logic        flashState, lapState, manualTrigger;
  logic        flashing, blank, tick;
  logic [23:0] digits;

  int checks = 0;
  int errors = 0;
  logic [24:0] sb[$];
  logic [24:0] e;

  stopwatch_count_datapath #(
    .TICK_DIV(TD), .BLINK_DIV(BD), .DIV_W(24)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .up(up),
    .resetCount(resetCount), .flashState(flashState),
    .lapState(lapState), .manualTrigger(manualTrigger),
    .flashing(flashing), .digits(digits),
    .blank(blank), .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic run_ticks(input int n);
    int seen = 0;
    int cyc = 0;
    enable = 1'b1;
    while (seen < n && cyc < n * TD + 20) begin
      @(negedge clk);
      cyc++;
      if (tick) seen++;
    end
    enable = 1'b0;
    checks++;
    if (seen != n) begin
      errors++;
      $display("FAIL run_ticks: got %0d ticks, want %0d", seen, n);
    end
  endtask

  task automatic jog_pulse();
    manualTrigger = 1'b1;
    @(negedge clk);
    manualTrigger = 1'b0;
    @(negedge clk);
  endtask

  task automatic clear_count();
    resetCount = 1'b1;
    @(negedge clk);
    resetCount = 1'b0;
  endtask

  task automatic test_reset();
    int n = 0;
    sb.push_back({1'b0, ZERO_TIME});
    @(negedge clk);
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if ({flashing, digits} !== e || blank !== 1'b0 || tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got %h b%b t%b, want %h b0 t0",
               {flashing, digits}, blank, tick, e);
    end
    reset = 1'b0;
    up = 1'b1;
    run_ticks(37);
    sb.push_back({1'b0, 24'h000037});
    e = sb.pop_front();
    checks++;
    if ({flashing, digits} !== e) begin
      errors++;
      $display("FAIL pre_reset: got %h want %h", {flashing, digits}, e);
    end
    enable = 1'b1;
    #2 reset = 1'b1;
    sb.push_back({1'b0, ZERO_TIME});
    #1;
    e = sb.pop_front();
    checks++;
    if ({flashing, digits} !== e || blank !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got %h b%b want %h b0",
               {flashing, digits}, blank, e);
    end
    @(negedge clk);
    reset = 1'b0;
    sb.push_back({1'b0, 24'h000010});
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tick) n++;
    end
    enable = 1'b0;
    checks++;
    if (n != 10) begin
      errors++;
      $display("FAIL tick_count: got %0d want 10", n);
    end
    e = sb.pop_front();
    checks++;
    if ({flashing, digits} !== e) begin
      errors++;
      $display("FAIL count_40: got %h want %h", {flashing, digits}, e);
    end
  endtask

  task automatic test_count_down();
    logic [24:0] exp [5];
    exp = '{25'h0000100, 25'h0000099, 25'h0000001,
            25'h0000000, 25'h1000000};
    clear_count();
    up = 1'b1;
    sb.push_back(exp[0]);
    jog_pulse();
    e = sb.pop_front();
    checks++;
    if ({flashing, digits} !== e) begin
      errors++;
      $display("FAIL jog_100: got %h want %h", {flashing, digits}, e);
    end
    for (int k = 1; k < 5; k++) begin
      if (k == 2) begin
        clear_count();
        up = 1'b1;
      end else begin
        up = 1'b0;
      end
      sb.push_back(exp[k]);
      run_ticks(1);
      e = sb.pop_front();
      checks++;
      if ({flashing, digits} !== e) begin
        errors++;
        $display("FAIL down_%0d: got %h want %h", k, {flashing, digits}, e);
      end
    end
    sb.push_back({1'b0, ZERO_TIME});
    clear_count();
    e = sb.pop_front();
    checks++;
    if ({flashing, digits} !== e) begin
      errors++;
      $display("FAIL clr_flash: got %h want %h", {flashing, digits}, e);
    end
  endtask

  task automatic test_terminal_up();
    up = 1'b0;
    sb.push_back({1'b0, 24'h595900});
    jog_pulse();
    e = sb.pop_front();
    checks++;
    if ({flashing, digits} !== e) begin
      errors++;
      $display("FAIL jog_down0: got %h want %h", {flashing, digits}, e);
    end
    up = 1'b1;
    sb.push_back({1'b0, MAX_TIME});
    run_ticks(99);
    e = sb.pop_front();
    checks++;
    if ({flashing, digits} !== e) begin
      errors++;
      $display("FAIL to_max: got %h want %h", {flashing, digits}, e);
    end
`ifdef STOPWATCH_WRAP_EN
    sb.push_back({1'b0, ZERO_TIME});
    sb.push_back({1'b0, 24'h000001});
`else
    sb.push_back({1'b1, MAX_TIME});
    sb.push_back({1'b1, MAX_TIME});
`endif
    for (int k = 0; k < 2; k++) begin
      run_ticks(1);
      e = sb.pop_front();
      checks++;
      if ({flashing, digits} !== e) begin
        errors++;
        $display("FAIL max_tick%0d: got %h want %h", k, {flashing, digits}, e);
      end
    end
    clear_count();
  endtask

  task automatic test_lap();
    up = 1'b1;
    run_ticks(25);
    lapState = 1'b1;
    sb.push_back({1'b0, 24'h000025});
    sb.push_back({1'b0, 24'h000025});
    sb.push_back({1'b0, 24'h000045});
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if ({flashing, digits} !== e) begin
      errors++;
      $display("FAIL lap_cap: got %h want %h", {flashing, digits}, e);
    end
    run_ticks(20);
    e = sb.pop_front();
    checks++;
    if ({flashing, digits} !== e) begin
      errors++;
      $display("FAIL lap_hold: got %h want %h", {flashing, digits}, e);
    end
    lapState = 1'b0;
    #1;
    e = sb.pop_front();
    checks++;
    if ({flashing, digits} !== e) begin
      errors++;
      $display("FAIL lap_rel: got %h want %h", {flashing, digits}, e);
    end
    @(negedge clk);
  endtask

  task automatic test_jog();
    int n = 0;
    clear_count();
    up = 1'b1;
    sb.push_back({1'b0, 24'h000300});
    for (int k = 0; k < 3; k++) jog_pulse();
    e = sb.pop_front();
    checks++;
    if ({flashing, digits} !== e) begin
      errors++;
      $display("FAIL jog_x3: got %h want %h", {flashing, digits}, e);
    end
    sb.push_back({1'b0, 24'h000400});
    manualTrigger = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tick) n++;
    end
    manualTrigger = 1'b0;
    enable = 1'b0;
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL jog_hold_ticks: got %0d want 0", n);
    end
    e = sb.pop_front();
    checks++;
    if ({flashing, digits} !== e) begin
      errors++;
      $display("FAIL jog_hold: got %h want %h", {flashing, digits}, e);
    end
  endtask

  task automatic test_blink();
    logic eb;
    flashState = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      eb = ((i / BD) % 2) == 1;
      checks++;
      if (blank !== eb) begin
        errors++;
        $display("FAIL blink_%0d: got %b want %b", i, blank, eb);
      end
    end
    flashState = 1'b0;
    @(negedge clk);
    checks++;
    if (blank !== 1'b0) begin
      errors++;
      $display("FAIL blink_off: got %b want 0", blank);
    end
  endtask

  task automatic test_clear_priority();
    up = 1'b1;
    sb.push_back({1'b0, ZERO_TIME});
    sb.push_back({1'b0, 24'h000100});
    resetCount = 1'b1;
    manualTrigger = 1'b1;
    @(negedge clk);
    resetCount = 1'b0;
    manualTrigger = 1'b0;
    e = sb.pop_front();
    checks++;
    if ({flashing, digits} !== e) begin
      errors++;
      $display("FAIL clr_wins: got %h want %h", {flashing, digits}, e);
    end
    @(negedge clk);
    jog_pulse();
    e = sb.pop_front();
    checks++;
    if ({flashing, digits} !== e) begin
      errors++;
      $display("FAIL jog_after: got %h want %h", {flashing, digits}, e);
    end
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    up = 1'b1;
    resetCount = 1'b0;
    flashState = 1'b0;
    lapState = 1'b0;
    manualTrigger = 1'b0;
    test_reset();
    test_count_down();
    test_terminal_up();
    test_lap();
    test_jog();
    test_blink();
    test_clear_priority();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/stopwatch_count_datapath.md
Name: stopwatch_count_datapath

Overview:
Datapath end of the stopwatch control interface. It consumes the controller's enable/up/resetCount/flashState/lapState/manualTrigger outputs and holds an MM:SS.hh BCD time count with a 100 Hz prescaler. It drives the six display digits, a blink blank for Flash, and the `flashing` terminal-count flag back to the controller. It sits between the controller FSM and the 7-segment display mux.

Parameters:
TICK_DIV, 500000, clk cycles per hundredth tick (50 MHz -> 100 Hz)
BLINK_DIV, 12500000, clk cycles per blink half-period (4 Hz toggle -> 2 Hz blink)
DIV_W, 24, width of both divider counters; must hold TICK_DIV-1 and BLINK_DIV-1

Ports:
clk  in  1  system clock
reset  in  1  reset, asynchronous, active-high; clock clk
enable  in  1  count enable from controller
up  in  1  1 = count up, 0 = count down
resetCount  in  1  synchronous clear of count, prescaler, flashing
flashState  in  1  controller is in Flash; enables blink
lapState  in  1  controller is in Lap; freeze displayed value
manualTrigger  in  1  time-jog step request (level; edge-detected here)
flashing  out  1  terminal count reached (to controller)
digits  out  24  {M1,M0,S1,S0,H1,H0} BCD, 4 bits each, M1 most significant
blank  out  1  1 = display dark (blink phase)
tick  out  1  one-clk pulse per hundredth advance (debug/LED)

Behaviour:
- Reset (async): count=00:00.00, lap_reg=00:00.00, prescaler=0, blink counter=0, flashing=0, blank=0, tick=0, trigger edge register=0.
- Priority per clk: resetCount > manualTrigger edge > prescaler tick.
- resetCount=1: next edge count=0, prescaler=0, flashing=0, tick=0. lap_reg is unchanged.
- Prescaler: increments when enable=1 and resetCount=0. At TICK_DIV-1 it wraps to 0 and asserts tick for 1 clk. With enable=0 it holds its value and does not clear.
- Tick with up=1: increment hundredths with BCD carry. Limits: H 0-99, S 0-59, M 0-59.
- Tick with up=0: decrement with BCD borrow.
- Terminal (no STOPWATCH_WRAP_EN): tick while up=1 and count=59:59.99, or up=0 and count=00:00.00. Count holds, flashing is set on the next edge and stays set until resetCount. While flashing=1, further ticks do not change count.
- Jog: a rising edge of manualTrigger (registered copy, 1 clk latency) steps seconds by +/-1 per `up`. Carry/borrow goes into minutes, which wrap modulo 60. Jog never sets flashing. Hundredths are untouched. The prescaler tick is suppressed in any cycle where manualTrigger=1.
- Lap: on the rising edge of lapState, lap_reg <= count. digits = lapState ? lap_reg : count. The count keeps running underneath.
- Blink: blink counter runs while flashState=1 and toggles blank at BLINK_DIV-1. When flashState=0, counter=0 and blank=0 on the next edge.
- Outputs are registered or a direct mux of registers. There are no combinational paths from inputs to outputs except the digits mux on lapState.
- Reset asserted mid-count returns everything to reset values immediately. The first tick after reset release is at most TICK_DIV clks later.

Optional Feature:
STOPWATCH_WRAP_EN
- Defined: count-up at 59:59.99 wraps to 00:00.00 on tick and flashing stays 0. Count-down terminal behaviour is unchanged.
- Undefined: both directions saturate and set flashing as described under Behaviour.

Decomposition:
- Package stopwatch_pkg holds:
  - BCD digit width (4)
  - digit limit constants (H_MAX=9, H1_MAX=9, S1_MAX=5, M1_MAX=5)
  - packed digits vector layout/offsets
  - MAX_TIME (24'h595999) and ZERO_TIME
- One natural sub-module, bcd_digit: one digit with MAX parameter, inc/dec, carry_in/borrow_in, carry_out/borrow_out, sync clear. It is instantiated six times in a ripple chain. Jog enters the chain at S0.

Test Plan:
1. Assert reset mid-count at 00:00.37 -> digits=24'h000000, flashing=0, blank=0 within the same cycle. After release with TICK_DIV=4, enable=1, up=1 for 40 clks -> digits=24'h000010, 10 tick pulses.
2. up=0, count=00:01.00, one tick -> 24'h000099. Preset 00:00.01, two ticks -> 24'h000000 then flashing=1 with digits holding 24'h000000. resetCount 1 clk -> flashing=0.
3. From zero, one jog with up=0 -> 24'h595900. Then 99 ticks up=1 -> 24'h595999. Next tick -> flashing=1, count holds. With STOPWATCH_WRAP_EN -> 24'h000000, flashing=0.
4. lapState rises at 00:00.25 and is held 20 ticks -> digits stay 24'h000025. lapState falls -> digits=24'h000045.
5. From zero, three manualTrigger pulses, up=1 -> 24'h000300. manualTrigger held high 10 clks with enable=1 -> only one step, no ticks counted.
6. BLINK_DIV=3, flashState=1 -> blank toggles every 3 clks. flashState=0 -> blank=0 next edge. resetCount together with manualTrigger edge -> count=0 (clear wins).
